// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 10-bit pipelined CPU; forwards operands, runs the ALU or half-word insert, and registers the result into a stallable EX pipeline register.
//   in : clk, reset (sync, active-low), rs_in/rt_in/signextimm, ALU_EX/ALU_M/Mem_M forwarding sources,
//        ALU_sel, imm_sel, upper/lower_hw_en_in, half_word_in, rd_sel1/2_in, write_sel_EX/M,
//        reg_write_en_EX/M, MemtoReg_EX/M, MEM-bound control *_in, reg_writesel_in, cache_Ready
//   out: rs_out/rt_out (forwarded operands), ALU_result, registered MEM-bound control, reg_writesel_out
module execute_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] rs_in,
  input  logic [9:0] rt_in,
  input  logic [9:0] signextimm,
  input  logic [9:0] ALU_EX,
  input  logic [9:0] ALU_M,
  input  logic [9:0] Mem_M,
  input  logic [1:0] ALU_sel,
  input  logic       imm_sel,
  input  logic       upper_hw_en_in,
  input  logic       lower_hw_en_in,
  input  logic [4:0] half_word_in,
  input  logic [2:0] rd_sel1_in,
  input  logic [2:0] rd_sel2_in,
  input  logic [2:0] write_sel_EX,
  input  logic [2:0] write_sel_M,
  input  logic       reg_write_en_EX,
  input  logic       MemtoReg_EX,
  input  logic       reg_write_en_M,
  input  logic       MemtoReg_M,
  input  logic       reg_write_en_in,
  input  logic       RAM_writeEnable_in,
  input  logic       MemtoReg_in,
  input  logic       PC_en_in,
  input  logic [2:0] reg_writesel_in,
  input  logic       cache_Ready,
  output logic [9:0] rs_out,
  output logic [9:0] rt_out,
  output logic [9:0] ALU_result,
  output logic       reg_write_en_out,
  output logic       RAM_writeEnable_out,
  output logic       MemtoReg_out,
  output logic       PC_en_out,
  output logic [2:0] reg_writesel_out
);
  logic [1:0] w_fwd_a, w_fwd_b;
  logic [9:0] w_op_a, w_op_b, w_base_b, w_alu, w_ex;
  logic [9:0] r_rs, r_rt, r_res;
  logic       r_rwe, r_ramwe, r_m2r, r_pc;
  logic [2:0] r_wsel;
  // EX/MEM hit beats MEM/WB hit; an EX-stage load cannot be forwarded yet, so it never matches.
  always_comb begin
    w_fwd_a = (reg_write_en_EX && !MemtoReg_EX && write_sel_EX == rd_sel1_in) ? 2'b01 :
              (reg_write_en_M && !MemtoReg_M && write_sel_M == rd_sel1_in)    ? 2'b10 :
              (reg_write_en_M &&  MemtoReg_M && write_sel_M == rd_sel1_in)    ? 2'b11 : 2'b00;
    w_fwd_b = imm_sel                                                         ? 2'b00 :
              (reg_write_en_EX && !MemtoReg_EX && write_sel_EX == rd_sel2_in) ? 2'b01 :
              (reg_write_en_M && !MemtoReg_M && write_sel_M == rd_sel2_in)    ? 2'b10 :
              (reg_write_en_M &&  MemtoReg_M && write_sel_M == rd_sel2_in)    ? 2'b11 : 2'b00;
    w_base_b = imm_sel ? signextimm : rt_in;
    w_op_a = w_fwd_a == 2'b01 ? ALU_EX : w_fwd_a == 2'b10 ? ALU_M : w_fwd_a == 2'b11 ? Mem_M : rs_in;
    w_op_b = w_fwd_b == 2'b01 ? ALU_EX : w_fwd_b == 2'b10 ? ALU_M : w_fwd_b == 2'b11 ? Mem_M : w_base_b;
    w_alu = ALU_sel == 2'b00 ? w_op_a + w_op_b :
            ALU_sel == 2'b01 ? w_op_a - w_op_b :
            ALU_sel == 2'b10 ? w_op_a & w_op_b : w_op_a | w_op_b;
    // Lower insert wins when both enables are set.
    w_ex = lower_hw_en_in ? {w_op_a[9:5], half_word_in} :
           upper_hw_en_in ? {half_word_in, w_op_a[4:0]} : w_alu;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rs    <= '0;
      r_rt    <= '0;
      r_res   <= '0;
      r_rwe   <= 1'b0;
      r_ramwe <= 1'b0;
      r_m2r   <= 1'b0;
      r_pc    <= 1'b0;
      r_wsel  <= '0;
    end else if (cache_Ready) begin
      r_rs    <= w_op_a;
      r_rt    <= w_op_b;
      r_res   <= w_ex;
      r_rwe   <= reg_write_en_in;
      r_ramwe <= RAM_writeEnable_in;
      r_m2r   <= MemtoReg_in;
      r_pc    <= PC_en_in;
      r_wsel  <= reg_writesel_in;
    end
  end
  assign rs_out              = r_rs;
  assign rt_out              = r_rt;
  assign ALU_result          = r_res;
  assign reg_write_en_out    = r_rwe;
  assign RAM_writeEnable_out = r_ramwe;
  assign MemtoReg_out        = r_m2r;
  assign PC_en_out           = r_pc;
  assign reg_writesel_out    = r_wsel;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed plus randomized check of execute_stage against a behavioural reference model.
module tb_execute_stage;
  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] rs_in, rt_in, signextimm, ALU_EX, ALU_M, Mem_M;
  logic [1:0] ALU_sel;
  logic       imm_sel, upper_hw_en_in, lower_hw_en_in;
  logic [4:0] half_word_in;
  logic [2:0] rd_sel1_in, rd_sel2_in, write_sel_EX, write_sel_M, reg_writesel_in;
  logic       reg_write_en_EX, MemtoReg_EX, reg_write_en_M, MemtoReg_M;
  logic       reg_write_en_in, RAM_writeEnable_in, MemtoReg_in, PC_en_in, cache_Ready;
  logic [9:0] rs_out, rt_out, ALU_result;
  logic       reg_write_en_out, RAM_writeEnable_out, MemtoReg_out, PC_en_out;
  logic [2:0] reg_writesel_out;
  logic [9:0] e_rs, e_rt, e_res;
  logic [6:0] e_ctl;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  execute_stage dut (
    .clk(clk), .reset(reset), .rs_in(rs_in), .rt_in(rt_in), .signextimm(signextimm),
    .ALU_EX(ALU_EX), .ALU_M(ALU_M), .Mem_M(Mem_M), .ALU_sel(ALU_sel), .imm_sel(imm_sel),
    .upper_hw_en_in(upper_hw_en_in), .lower_hw_en_in(lower_hw_en_in), .half_word_in(half_word_in),
    .rd_sel1_in(rd_sel1_in), .rd_sel2_in(rd_sel2_in), .write_sel_EX(write_sel_EX), .write_sel_M(write_sel_M),
    .reg_write_en_EX(reg_write_en_EX), .MemtoReg_EX(MemtoReg_EX), .reg_write_en_M(reg_write_en_M),
    .MemtoReg_M(MemtoReg_M), .reg_write_en_in(reg_write_en_in), .RAM_writeEnable_in(RAM_writeEnable_in),
    .MemtoReg_in(MemtoReg_in), .PC_en_in(PC_en_in), .reg_writesel_in(reg_writesel_in), .cache_Ready(cache_Ready),
    .rs_out(rs_out), .rt_out(rt_out), .ALU_result(ALU_result), .reg_write_en_out(reg_write_en_out),
    .RAM_writeEnable_out(RAM_writeEnable_out), .MemtoReg_out(MemtoReg_out), .PC_en_out(PC_en_out),
    .reg_writesel_out(reg_writesel_out)
  );
  task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  // Value a source register would hold after applying the newest in-flight write to it.
  function automatic logic [9:0] newest(input logic [2:0] idx, input logic [9:0] from_rf);
    if (reg_write_en_EX && !MemtoReg_EX && write_sel_EX == idx) return ALU_EX;
    if (reg_write_en_M && write_sel_M == idx) return MemtoReg_M ? Mem_M : ALU_M;
    return from_rf;
  endfunction
  task step(input string tag);
    logic [9:0] a, b, alu, res;
    a = newest(rd_sel1_in, rs_in);
    b = imm_sel ? signextimm : newest(rd_sel2_in, rt_in);
    case (ALU_sel)
      2'd0: alu = 10'((int'(a) + int'(b)) % 1024);
      2'd1: alu = 10'((int'(a) - int'(b) + 1024) % 1024);
      2'd2: alu = a & b;
      default: alu = a | b;
    endcase
    res = lower_hw_en_in ? {a[9:5], half_word_in} : upper_hw_en_in ? {half_word_in, a[4:0]} : alu;
    if (!reset) begin
      e_rs = 0; e_rt = 0; e_res = 0; e_ctl = 0;
    end else if (cache_Ready) begin
      e_rs = a; e_rt = b; e_res = res;
      e_ctl = {reg_write_en_in, RAM_writeEnable_in, MemtoReg_in, PC_en_in, reg_writesel_in};
    end
    @(posedge clk);
    #1;
    check({tag, ".rs"}, rs_out, e_rs);
    check({tag, ".rt"}, rt_out, e_rt);
    check({tag, ".res"}, ALU_result, e_res);
    check({tag, ".ctl"}, {reg_write_en_out, RAM_writeEnable_out, MemtoReg_out, PC_en_out, reg_writesel_out}, e_ctl);
  endtask
  task randomize_inputs();
    rs_in = 10'($urandom); rt_in = 10'($urandom); signextimm = 10'($urandom);
    ALU_EX = 10'($urandom); ALU_M = 10'($urandom); Mem_M = 10'($urandom);
    ALU_sel = 2'($urandom); imm_sel = 1'($urandom);
    upper_hw_en_in = ($urandom_range(0, 3) == 0); lower_hw_en_in = ($urandom_range(0, 3) == 0);
    half_word_in = 5'($urandom);
    rd_sel1_in = 3'($urandom); rd_sel2_in = 3'($urandom);
    write_sel_EX = 3'($urandom); write_sel_M = 3'($urandom);
    reg_write_en_EX = 1'($urandom); MemtoReg_EX = 1'($urandom);
    reg_write_en_M = 1'($urandom); MemtoReg_M = 1'($urandom);
    reg_write_en_in = 1'($urandom); RAM_writeEnable_in = 1'($urandom);
    MemtoReg_in = 1'($urandom); PC_en_in = 1'($urandom); reg_writesel_in = 3'($urandom);
  endtask
  task fwd_setup();
    rd_sel1_in = 3'd5; rd_sel2_in = 3'd5; rs_in = 10'h017; rt_in = 10'h001; imm_sel = 1'b0;
    ALU_EX = 10'h001; ALU_M = 10'h001; Mem_M = 10'h002; ALU_sel = 2'b00;
    upper_hw_en_in = 1'b0; lower_hw_en_in = 1'b0;
    reg_write_en_EX = 1'b0; MemtoReg_EX = 1'b0; reg_write_en_M = 1'b0; MemtoReg_M = 1'b0;
    write_sel_EX = 3'd4; write_sel_M = 3'd4;
  endtask
  initial begin
    logic [9:0] held;
    randomize_inputs();
    reset = 1'b0; cache_Ready = 1'b1;
    step("reset");
    check("reset.rs0", rs_out, 0);
    check("reset.res0", ALU_result, 0);
    reset = 1'b1;
    fwd_setup();
    reg_write_en_EX = 1'b1; write_sel_EX = 3'd5;
    step("fwd_ex");
    check("fwd_ex.k", ALU_result, 10'h002);
    write_sel_EX = 3'd4; reg_write_en_M = 1'b1; write_sel_M = 3'd5;
    step("fwd_m");
    check("fwd_m.k", ALU_result, 10'h002);
    MemtoReg_M = 1'b1;
    step("fwd_mem");
    check("fwd_mem.k", ALU_result, 10'h004);
    reg_write_en_EX = 1'b0; reg_write_en_M = 1'b0;
    step("fwd_none");
    check("fwd_none.k", ALU_result, 10'h018);
    fwd_setup();
    imm_sel = 1'b1; signextimm = 10'h004; rd_sel1_in = 3'd1; reg_write_en_M = 1'b1; write_sel_M = 3'd5;
    step("imm");
    check("imm.k", ALU_result, 10'h01B);
    check("imm.rt", rt_out, 10'h004);
    fwd_setup();
    rs_in = 10'h3F0; rt_in = 10'h01F;
    for (int i = 0; i < 4; i++) begin
      logic [9:0] want [4];
      want = '{10'h00F, 10'h3D1, 10'h010, 10'h3FF};
      ALU_sel = 2'(i);
      step("op");
      check("op.k", ALU_result, want[i]);
    end
    fwd_setup();
    ALU_sel = 2'b00; half_word_in = 5'h0A;
    upper_hw_en_in = 1'b1;
    step("hw_up");
    check("hw_up.k", ALU_result, 10'h157);
    upper_hw_en_in = 1'b0; lower_hw_en_in = 1'b1;
    step("hw_lo");
    check("hw_lo.k", ALU_result, 10'h00A);
    upper_hw_en_in = 1'b1;
    step("hw_both");
    check("hw_both.k", ALU_result, 10'h00A);
    held = ALU_result;
    cache_Ready = 1'b0;
    randomize_inputs();
    upper_hw_en_in = 1'b0; lower_hw_en_in = 1'b0; imm_sel = 1'b1; signextimm = 10'h123; ALU_sel = 2'b11;
    step("stall");
    check("stall.k", ALU_result, held);
    cache_Ready = 1'b1;
    step("resume");
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      reset = ($urandom_range(0, 15) != 0);
      cache_Ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
